// File: rtl/dmem_arbiter_if.sv
// Core/NIC request ports plus the single-port Dmem pins shared by dmem_arbiter.
// slave = arbiter side; master = requesters and the memory model.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
);
  logic              c_req;
  logic              c_wr;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_gnt;
  logic              c_rvalid;
  logic [DATA_W-1:0] c_rdata;

  logic              n_req;
  logic              n_wr;
  logic [ADDR_W-1:0] n_addr;
  logic [DATA_W-1:0] n_wdata;
  logic              n_gnt;
  logic              n_rvalid;
  logic [DATA_W-1:0] n_rdata;

  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Data_Out;
  logic [DATA_W-1:0] Data_In;
  logic              DmemEn;
  logic              DmemWrEn;

  modport slave (
    input  c_req, c_wr, c_addr, c_wdata, n_req, n_wr, n_addr, n_wdata, Data_In,
    output c_gnt, c_rvalid, c_rdata, n_gnt, n_rvalid, n_rdata,
           Mem_Addr, Data_Out, DmemEn, DmemWrEn
  );

  modport master (
    output c_req, c_wr, c_addr, c_wdata, n_req, n_wr, n_addr, n_wdata, Data_In,
    input  c_gnt, c_rvalid, c_rdata, n_gnt, n_rvalid, n_rdata,
           Mem_Addr, Data_Out, DmemEn, DmemWrEn
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Core/NIC arbiter for single-port Dmem: combinational grant, read data 1 cycle later, bounded-burst round robin.
// Losing side stalls (req && !gnt); optional DMEM_ARB_PERF_EN adds conflict/stall counters.
module dmem_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 64,
  parameter int MAX_BURST = 4
) (
  input  logic         Clock,
  input  logic         Reset,
`ifdef DMEM_ARB_PERF_EN
  input  logic         perf_clr,
  output logic [15:0]  cnt_conflict,
  output logic [15:0]  cnt_cstall,
`endif
  dmem_arbiter_if.slave bus
);

  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
    $error("dmem_arbiter: MAX_BURST must be in 1..15");
  end

  typedef enum logic {
    PRI_C = 1'b0,
    PRI_N = 1'b1
  } pri_e;

  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  pri_e       pri_q, pri_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rd_c_q, rd_c_d;
  logic       rd_n_q, rd_n_d;
  logic       c_gnt, n_gnt;
  logic       other_req;

  // Grants are forced low in reset so nothing reaches the Dmem pins.
  always_comb begin
    c_gnt = 1'b0;
    n_gnt = 1'b0;
    if (!Reset) begin
      if (bus.c_req && bus.n_req) begin
        c_gnt = (pri_q == PRI_C);
        n_gnt = (pri_q == PRI_N);
      end else begin
        c_gnt = bus.c_req;
        n_gnt = bus.n_req;
      end
    end
  end

  always_comb begin
    bus.c_gnt    = c_gnt;
    bus.n_gnt    = n_gnt;
    bus.DmemEn   = c_gnt | n_gnt;
    bus.DmemWrEn = (c_gnt & bus.c_wr) | (n_gnt & bus.n_wr);
    bus.Mem_Addr = c_gnt ? bus.c_addr  : (n_gnt ? bus.n_addr  : '0);
    bus.Data_Out = c_gnt ? bus.c_wdata : (n_gnt ? bus.n_wdata : '0);
    bus.c_rvalid = rd_c_q & ~Reset;
    bus.n_rvalid = rd_n_q & ~Reset;
    bus.c_rdata  = (rd_c_q & ~Reset) ? bus.Data_In : '0;
    bus.n_rdata  = (rd_n_q & ~Reset) ? bus.Data_In : '0;
  end

  // Contested grants count toward the burst limit; an uncontested grant
  // makes the granted side owner with a fresh burst.
  always_comb begin
    pri_d     = pri_q;
    cnt_d     = cnt_q;
    other_req = c_gnt ? bus.n_req : bus.c_req;
    if (c_gnt || n_gnt) begin
      if (other_req) begin
        if (cnt_q == BURST_LAST) begin
          pri_d = c_gnt ? PRI_N : PRI_C;
          cnt_d = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end else begin
        pri_d = c_gnt ? PRI_C : PRI_N;
        cnt_d = 4'd0;
      end
    end
    rd_c_d = c_gnt & ~bus.c_wr;
    rd_n_d = n_gnt & ~bus.n_wr;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pri_q  <= PRI_C;
      cnt_q  <= 4'd0;
      rd_c_q <= 1'b0;
      rd_n_q <= 1'b0;
    end else begin
      pri_q  <= pri_d;
      cnt_q  <= cnt_d;
      rd_c_q <= rd_c_d;
      rd_n_q <= rd_n_d;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [15:0] conflict_q, conflict_d;
  logic [15:0] cstall_q, cstall_d;

  always_comb begin
    conflict_d = conflict_q;
    cstall_d   = cstall_q;
    if (perf_clr) begin
      conflict_d = 16'd0;
      cstall_d   = 16'd0;
    end else begin
      if (bus.c_req && bus.n_req && conflict_q != 16'hFFFF) conflict_d = conflict_q + 16'd1;
      if (bus.c_req && !c_gnt && cstall_q != 16'hFFFF)      cstall_d   = cstall_q + 16'd1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      conflict_q <= 16'd0;
      cstall_q   <= 16'd0;
    end else begin
      conflict_q <= conflict_d;
      cstall_q   <= cstall_d;
    end
  end

  assign cnt_conflict = conflict_q;
  assign cnt_cstall   = cstall_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a reference model
// with its own shadow memory; a second instance with MAX_BURST=1 checks strict alternation.
module tb_dmem_arbiter;
  localparam int AW  = 8;
  localparam int DW  = 64;
  localparam int MB4 = 4;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus4 ();
  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

`ifdef DMEM_ARB_PERF_EN
  logic        perf_clr;
  logic [15:0] cnt_conflict, cnt_cstall, cnt_conflict1, cnt_cstall1;
`endif

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(4)) u_dut4 (
    .Clock        (Clock),
    .Reset        (Reset),
`ifdef DMEM_ARB_PERF_EN
    .perf_clr     (perf_clr),
    .cnt_conflict (cnt_conflict),
    .cnt_cstall   (cnt_cstall),
`endif
    .bus          (bus4)
  );

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(1)) u_dut1 (
    .Clock        (Clock),
    .Reset        (Reset),
`ifdef DMEM_ARB_PERF_EN
    .perf_clr     (perf_clr),
    .cnt_conflict (cnt_conflict1),
    .cnt_cstall   (cnt_cstall1),
`endif
    .bus          (bus1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Environment memory answers the DUT pins; the reference memory follows the model only.
  logic [63:0] env_mem [256];
  logic [63:0] ref_mem [256];
  logic        env_en, env_we;
  logic [7:0]  env_addr;
  logic [63:0] env_wd;

  // Reference model: which side is favoured under contention and how many
  // contested grants it has already taken.
  int          m_owner;   // 0 core, 1 NIC
  int          m_run;
  int          cur_g;     // grant predicted for the cycle just sampled: 0 none, 1 C, 2 N
  bit          m_rv_c, m_rv_n;
  logic [63:0] m_rd_c, m_rd_n;
  bit          c_pend, n_pend;
`ifdef DMEM_ARB_PERF_EN
  int          m_conf, m_stall;
`endif

  function automatic logic [63:0] init_word(input int i);
    return {32'(i) ^ 32'h5A5A0000, 32'hC0DE0000 + 32'(i * 3)};
  endfunction

  task automatic step_edge();
    int other;
    @(posedge Clock);
    #1;
    if (env_en && env_we) env_mem[env_addr] = env_wd;
    bus4.Data_In = (env_en && !env_we) ? env_mem[env_addr] : {$urandom, $urandom};
`ifdef DMEM_ARB_PERF_EN
    if (Reset || perf_clr) begin
      m_conf = 0; m_stall = 0;
    end else begin
      if (bus4.c_req && bus4.n_req && m_conf < 65535) m_conf++;
      if (bus4.c_req && cur_g != 1 && m_stall < 65535) m_stall++;
    end
`endif
    if (Reset) begin
      m_owner = 0; m_run = 0; m_rv_c = 0; m_rv_n = 0;
    end else begin
      m_rv_c = (cur_g == 1) && !bus4.c_wr;
      m_rv_n = (cur_g == 2) && !bus4.n_wr;
      m_rd_c = ref_mem[bus4.c_addr];
      m_rd_n = ref_mem[bus4.n_addr];
      if (cur_g == 1 && bus4.c_wr) ref_mem[bus4.c_addr] = bus4.c_wdata;
      if (cur_g == 2 && bus4.n_wr) ref_mem[bus4.n_addr] = bus4.n_wdata;
      if (cur_g != 0) begin
        other = (cur_g == 1) ? int'(bus4.n_req) : int'(bus4.c_req);
        if (other == 0) begin
          m_owner = cur_g - 1; m_run = 0;
        end else begin
          m_run++;
          if (m_run == MB4) begin
            m_owner = (cur_g == 1) ? 1 : 0; m_run = 0;
          end
        end
      end
    end
  endtask

  task automatic sample();
    int          g;
    logic [7:0]  ea;
    logic [63:0] ed;
    logic        ew;
    @(negedge Clock);
    if (Reset)                          g = 0;
    else if (bus4.c_req && bus4.n_req)  g = (m_owner == 0) ? 1 : 2;
    else if (bus4.c_req)                g = 1;
    else if (bus4.n_req)                g = 2;
    else                                g = 0;
    ea = '0; ed = '0; ew = 1'b0;
    if (g == 1) begin ea = bus4.c_addr; ed = bus4.c_wdata; ew = bus4.c_wr; end
    if (g == 2) begin ea = bus4.n_addr; ed = bus4.n_wdata; ew = bus4.n_wr; end
    check("c_gnt",    64'(bus4.c_gnt),    64'(g == 1));
    check("n_gnt",    64'(bus4.n_gnt),    64'(g == 2));
    check("dmem_en",  64'(bus4.DmemEn),   64'(g != 0));
    check("dmem_we",  64'(bus4.DmemWrEn), 64'(ew));
    check("mem_addr", 64'(bus4.Mem_Addr), 64'(ea));
    check("data_out", bus4.Data_Out,      ed);
    check("c_rvalid", 64'(bus4.c_rvalid), 64'(!Reset && m_rv_c));
    check("n_rvalid", 64'(bus4.n_rvalid), 64'(!Reset && m_rv_n));
    check("c_rdata",  bus4.c_rdata, (!Reset && m_rv_c) ? m_rd_c : 64'd0);
    check("n_rdata",  bus4.n_rdata, (!Reset && m_rv_n) ? m_rd_n : 64'd0);
`ifdef DMEM_ARB_PERF_EN
    check("cnt_conflict", 64'(cnt_conflict), 64'(m_conf));
    check("cnt_cstall",   64'(cnt_cstall),   64'(m_stall));
`endif
    cur_g    = g;
    env_en   = bus4.DmemEn;
    env_we   = bus4.DmemWrEn;
    env_addr = bus4.Mem_Addr;
    env_wd   = bus4.Data_Out;
  endtask

  task automatic idle4();
    bus4.c_req = 0; bus4.c_wr = 0; bus4.c_addr = '0; bus4.c_wdata = '0;
    bus4.n_req = 0; bus4.n_wr = 0; bus4.n_addr = '0; bus4.n_wdata = '0;
  endtask

  task automatic reset_cycle();
    step_edge(); Reset = 1; idle4(); sample();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end
    Reset = 1; idle4();
    m_owner = 0; m_run = 0; cur_g = 0; m_rv_c = 0; m_rv_n = 0;
    m_rd_c = '0; m_rd_n = '0; c_pend = 0; n_pend = 0;
    env_en = 0; env_we = 0; env_addr = '0; env_wd = '0;
    bus4.Data_In = '0;
`ifdef DMEM_ARB_PERF_EN
    perf_clr = 0; m_conf = 0; m_stall = 0;
`endif
    bus1.c_req = 1; bus1.c_wr = 1; bus1.c_addr = 8'h01; bus1.c_wdata = 64'h1111_2222_3333_4444;
    bus1.n_req = 1; bus1.n_wr = 0; bus1.n_addr = 8'h02; bus1.n_wdata = 64'h0;
    bus1.Data_In = 64'h77;

    // reset, then idle, then a single core read returning 64'hA5
    repeat (2) begin step_edge(); sample(); end
    step_edge(); Reset = 0; sample();
    for (int k = 0; k < 5; k++) begin
      step_edge(); sample();
      check("idle_en",  64'(bus4.DmemEn),   64'd0);
      check("idle_rv",  64'(bus4.c_rvalid), 64'd0);
      check("idle_gnt", 64'(bus4.n_gnt),    64'd0);
    end
    env_mem[16] = 64'hA5; ref_mem[16] = 64'hA5;
    step_edge(); bus4.c_req = 1; bus4.c_wr = 0; bus4.c_addr = 8'h10; sample();
    check("rd_gnt", 64'(bus4.c_gnt),    64'd1);
    check("rd_en",  64'(bus4.DmemEn),   64'd1);
    check("rd_nrv", 64'(bus4.n_rvalid), 64'd0);
    step_edge(); bus4.c_req = 0; sample();
    check("rd_rv",   64'(bus4.c_rvalid), 64'd1);
    check("rd_data", bus4.c_rdata,       64'hA5);
    check("rd_nrv1", 64'(bus4.n_rvalid), 64'd0);

    // dual continuous reads: bursts of 4 on u_dut4, strict alternation on u_dut1
    reset_cycle();
    for (int k = 0; k < 12; k++) begin
      step_edge();
      if (k == 0) begin
        Reset = 0;
        bus4.c_req = 1; bus4.c_wr = 0; bus4.c_addr = 8'h03;
        bus4.n_req = 1; bus4.n_wr = 0; bus4.n_addr = 8'h04;
      end
      sample();
      check("burst_c",  64'(bus4.c_gnt),    64'((k % 8) < 4));
      check("burst_n",  64'(bus4.n_gnt),    64'((k % 8) >= 4));
      check("burst_we", 64'(bus4.DmemWrEn), 64'd0);
      check("alt_c",    64'(bus1.c_gnt),    64'(k % 2 == 0));
      check("alt_n",    64'(bus1.n_gnt),    64'(k % 2 == 1));
      check("alt_we",   64'(bus1.DmemWrEn), 64'(k % 2 == 0));
      check("alt_addr", 64'(bus1.Mem_Addr), (k % 2 == 0) ? 64'h01 : 64'h02);
      check("alt_dout", bus1.Data_Out, (k % 2 == 0) ? 64'h1111_2222_3333_4444 : 64'd0);
      check("alt_nrv",  64'(bus1.n_rvalid), 64'(k >= 2 && k % 2 == 0));
      check("alt_nrd",  bus1.n_rdata, (k >= 2 && k % 2 == 0) ? 64'h77 : 64'd0);
      check("alt_crv",  64'(bus1.c_rvalid), 64'd0);
      check("alt_crd",  bus1.c_rdata,       64'd0);
    end

    // core alone for 10 cycles, then NIC joins: 4 more core grants, then NIC
    reset_cycle();
    for (int k = 0; k < 15; k++) begin
      step_edge();
      if (k == 0) begin
        Reset = 0; bus4.c_req = 1; bus4.c_wr = 1; bus4.c_addr = 8'h05; bus4.c_wdata = 64'hBEEF;
      end
      if (k == 10) begin bus4.n_req = 1; bus4.n_wr = 0; bus4.n_addr = 8'h05; end
      sample();
      check("solo_c", 64'(bus4.c_gnt), 64'(k < 14));
      check("solo_n", 64'(bus4.n_gnt), 64'(k == 14));
    end

    // 4th contested core read hands priority to NIC; Reset next cycle must
    // drop that read's return and restore core priority
    reset_cycle();
    for (int k = 0; k < 4; k++) begin
      step_edge();
      if (k == 0) begin
        Reset = 0;
        bus4.c_req = 1; bus4.c_wr = 0; bus4.c_addr = 8'h07;
        bus4.n_req = 1; bus4.n_wr = 0; bus4.n_addr = 8'h08;
      end
      sample();
      check("pre_c", 64'(bus4.c_gnt), 64'd1);
    end
    step_edge(); Reset = 1; sample();
    check("rst_gnt", 64'(bus4.c_gnt),    64'd0);
    check("rst_en",  64'(bus4.DmemEn),   64'd0);
    check("rst_rv",  64'(bus4.c_rvalid), 64'd0);
    step_edge(); Reset = 0; sample();
    check("post_rv",  64'(bus4.c_rvalid), 64'd0);
    check("post_pri", 64'(bus4.c_gnt),    64'd1);
    check("post_n",   64'(bus4.n_gnt),    64'd0);

`ifdef DMEM_ARB_PERF_EN
    reset_cycle();
    for (int k = 0; k < 3; k++) begin
      step_edge();
      if (k == 0) begin
        Reset = 0;
        bus4.c_req = 1; bus4.c_wr = 0; bus4.c_addr = 8'h09;
        bus4.n_req = 1; bus4.n_wr = 0; bus4.n_addr = 8'h0A;
      end
      sample();
    end
    step_edge(); idle4(); sample();
    check("perf_conf3",  64'(cnt_conflict), 64'd3);
    check("perf_stall0", 64'(cnt_cstall),   64'd0);
    step_edge(); perf_clr = 1; sample();
    step_edge(); perf_clr = 0; sample();
    check("perf_clr_conf",  64'(cnt_conflict), 64'd0);
    check("perf_clr_stall", 64'(cnt_cstall),   64'd0);
`endif

    // random traffic with holds, cancels and occasional resets
    reset_cycle();
    c_pend = 0; n_pend = 0;
    for (int i = 0; i < 3000; i++) begin
      step_edge();
      if (cur_g == 1) c_pend = 0;
      if (cur_g == 2) n_pend = 0;
      Reset = ($urandom_range(0, 299) == 0);
`ifdef DMEM_ARB_PERF_EN
      perf_clr = ($urandom_range(0, 99) == 0);
`endif
      if (!c_pend && $urandom_range(0, 3) != 0) begin
        c_pend = 1; bus4.c_wr = 1'($urandom_range(0, 1));
        bus4.c_addr = 8'($urandom_range(0, 15)); bus4.c_wdata = {$urandom, $urandom};
      end else if (c_pend && $urandom_range(0, 15) == 0) begin
        c_pend = 0;
      end
      if (!n_pend && $urandom_range(0, 2) != 0) begin
        n_pend = 1; bus4.n_wr = 1'($urandom_range(0, 1));
        bus4.n_addr = 8'($urandom_range(0, 15)); bus4.n_wdata = {$urandom, $urandom};
      end else if (n_pend && $urandom_range(0, 15) == 0) begin
        n_pend = 0;
      end
      bus4.c_req = c_pend;
      bus4.n_req = n_pend;
      sample();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
